// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one single-port data SRAM between the CPU MEM stage and an external port.
// CPU normally wins; the external port is forced through after MAX_WAIT lost cycles. DRAM_ARBITER_STATS_EN adds grant/stall counters.
module dram_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              cpu_ren,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ext_req,
   input  logic              ext_wen,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       stat_ext_gnts,
   output logic [15:0]       stat_cpu_stalls
);
   logic              cpu_req, ext_win, cpu_gnt, rd_pend;
   logic [3:0]        wait_cnt;
   logic [DATA_W-1:0] rdata_hold;
   assign cpu_req = cpu_ren | cpu_wen;
   assign ext_win = ext_req & (~cpu_req | (wait_cnt == 4'(MAX_WAIT)));
   // grants are masked while in reset so nothing reaches the SRAM
   always_comb begin
      ext_gnt   = arst_n & ext_win;
      cpu_gnt   = arst_n & cpu_req & ~ext_win;
      cpu_stall = arst_n & cpu_req & ext_win;
      mem_wen   = ext_gnt ? ext_wen : cpu_gnt & cpu_wen;
      mem_ren   = ext_gnt ? ~ext_wen : cpu_gnt & ~cpu_wen;
      mem_addr  = ext_gnt ? ext_addr : cpu_gnt ? cpu_addr : '0;
      mem_wdata = ext_gnt ? ext_wdata : cpu_gnt ? cpu_wdata : '0;
      ext_rdata = ext_rvalid ? mem_rdata : '0;
      cpu_rdata = rd_pend ? mem_rdata : rdata_hold;
   end
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wait_cnt   <= '0;
         ext_rvalid <= 1'b0;
         rd_pend    <= 1'b0;
         rdata_hold <= '0;
      end else begin
         wait_cnt   <= (ext_gnt | ~ext_req) ? 4'd0 :
                       (cpu_req && wait_cnt < 4'(MAX_WAIT)) ? wait_cnt + 4'd1 : wait_cnt;
         ext_rvalid <= ext_gnt & ~ext_wen;
         rd_pend    <= cpu_gnt & ~cpu_wen;
         if (rd_pend) rdata_hold <= mem_rdata;
      end
   end
`ifdef DRAM_ARBITER_STATS_EN
   logic [15:0] gnt_cnt, stall_cnt;
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         gnt_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         gnt_cnt   <= gnt_cnt + 16'(ext_gnt && gnt_cnt != 16'hFFFF);
         stall_cnt <= stall_cnt + 16'(cpu_stall && stall_cnt != 16'hFFFF);
      end
   end
   assign stat_ext_gnts   = gnt_cnt;
   assign stat_cpu_stalls = stall_cnt;
`else
   assign stat_ext_gnts   = '0;
   assign stat_cpu_stalls = '0;
`endif
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_dram_arbiter;
   localparam int AW = 10, DW = 32, MW = 4;
`ifdef DRAM_ARBITER_STATS_EN
   localparam logic [15:0] EXP_ST = 16'd1;
`else
   localparam logic [15:0] EXP_ST = 16'd0;
`endif
   logic clk = 1'b0, arst_n = 1'b0;
   logic cpu_ren = 0, cpu_wen = 0, ext_req = 0, ext_wen = 0;
   logic [AW-1:0] cpu_addr = '0, ext_addr = '0;
   logic [DW-1:0] cpu_wdata = '0, ext_wdata = '0;
   logic [DW-1:0] cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
   logic cpu_stall, ext_gnt, ext_rvalid, mem_wen, mem_ren;
   logic [AW-1:0] mem_addr;
   logic [15:0] stat_ext_gnts, stat_cpu_stalls;
   logic [DW-1:0] sram [0:(1<<AW)-1] = '{default: '0};
   int errs = 0, checks = 0;

   always #5 clk = ~clk;

   dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .arst_n(arst_n),
      .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stat_ext_gnts(stat_ext_gnts), .stat_cpu_stalls(stat_cpu_stalls)
   );

   always @(posedge clk) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= sram[mem_addr];
   end

   task automatic drive(input logic cr, cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic er, ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
      @(negedge clk);
      cpu_ren = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
      ext_req = er; ext_wen = ew; ext_addr = ea; ext_wdata = ed;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic reset_pulse();
      idle();
      arst_n = 1'b0; #1; arst_n = 1'b1; #1;
   endtask

   task automatic test_reset();
      drive(1, 1, 10'h5, 32'h1, 1, 0, 10'h6, 32'h2);
      checks++; if (ext_gnt !== 1'b0) begin errs++; $display("FAIL rst_ext_gnt: got %b want 0", ext_gnt); end
      checks++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL rst_cpu_stall: got %b want 0", cpu_stall); end
      checks++; if ({mem_wen, mem_ren} !== 2'b00) begin errs++; $display("FAIL rst_mem_en: got %b want 00", {mem_wen, mem_ren}); end
      checks++; if (ext_rvalid !== 1'b0 || cpu_rdata !== '0) begin errs++; $display("FAIL rst_regs: rvalid %b cpu_rdata %h want 0 0", ext_rvalid, cpu_rdata); end
      checks++; if (stat_ext_gnts !== 16'd0 || stat_cpu_stalls !== 16'd0) begin errs++; $display("FAIL rst_stats: got %h %h want 0 0", stat_ext_gnts, stat_cpu_stalls); end
      idle();
      arst_n = 1'b1;
   endtask

   task automatic test_cpu_rw();
      drive(0, 1, 10'h010, 32'hDEADBEEF, 0, 0, '0, '0);
      checks++; if (mem_wen !== 1'b1 || mem_addr !== 10'h010 || mem_wdata !== 32'hDEADBEEF || cpu_stall !== 1'b0) begin errs++; $display("FAIL cpu_write: wen %b addr %h data %h stall %b want 1 010 deadbeef 0", mem_wen, mem_addr, mem_wdata, cpu_stall); end
      drive(1, 0, 10'h010, '0, 0, 0, '0, '0);
      checks++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || cpu_stall !== 1'b0) begin errs++; $display("FAIL cpu_read_issue: ren %b wen %b stall %b want 1 0 0", mem_ren, mem_wen, cpu_stall); end
      idle();
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL cpu_rdata: got %h want deadbeef", cpu_rdata); end
      idle();
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL cpu_rdata_hold: got %h want deadbeef", cpu_rdata); end
   endtask

   task automatic test_ext_read();
      drive(0, 0, '0, '0, 1, 1, 10'h020, 32'h12345678);
      checks++; if (ext_gnt !== 1'b1 || mem_wen !== 1'b1) begin errs++; $display("FAIL ext_write: gnt %b wen %b want 1 1", ext_gnt, mem_wen); end
      drive(0, 0, '0, '0, 1, 0, 10'h020, '0);
      checks++; if (ext_gnt !== 1'b1 || mem_ren !== 1'b1 || mem_addr !== 10'h020) begin errs++; $display("FAIL ext_read_gnt: gnt %b ren %b addr %h want 1 1 020", ext_gnt, mem_ren, mem_addr); end
      checks++; if (ext_rvalid !== 1'b0) begin errs++; $display("FAIL ext_rvalid_after_write: got %b want 0", ext_rvalid); end
      idle();
      checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h12345678) begin errs++; $display("FAIL ext_rdata: rvalid %b data %h want 1 12345678", ext_rvalid, ext_rdata); end
      idle();
      checks++; if (ext_rvalid !== 1'b0 || ext_rdata !== '0) begin errs++; $display("FAIL ext_rvalid_clear: rvalid %b data %h want 0 0", ext_rvalid, ext_rdata); end
   endtask

   task automatic test_starvation();
      reset_pulse();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 10'(10'h30 + i), 32'(32'hA0 + i), 1, 0, 10'h040, '0);
         checks++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 10'(10'h30 + i)) begin errs++; $display("FAIL starve_cpu_win%0d: gnt %b stall %b addr %h want 0 0 %h", i, ext_gnt, cpu_stall, mem_addr, 10'(10'h30 + i)); end
      end
      drive(0, 1, 10'h34, 32'hA4, 1, 0, 10'h040, '0);
      checks++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 10'h040) begin errs++; $display("FAIL starve_forced: gnt %b stall %b ren %b wen %b addr %h want 1 1 1 0 040", ext_gnt, cpu_stall, mem_ren, mem_wen, mem_addr); end
      drive(0, 1, 10'h34, 32'hA4, 1, 1, 10'h041, 32'h55);
      checks++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_wen !== 1'b1 || mem_addr !== 10'h34) begin errs++; $display("FAIL starve_retry: gnt %b stall %b wen %b addr %h want 0 0 1 034", ext_gnt, cpu_stall, mem_wen, mem_addr); end
      checks++; if (ext_rvalid !== 1'b1) begin errs++; $display("FAIL starve_rvalid: got %b want 1", ext_rvalid); end
      checks++; if (stat_ext_gnts !== EXP_ST || stat_cpu_stalls !== EXP_ST) begin errs++; $display("FAIL stats: got %0d %0d want %0d %0d", stat_ext_gnts, stat_cpu_stalls, EXP_ST, EXP_ST); end
      drive(0, 0, '0, '0, 1, 1, 10'h041, 32'h55);
      checks++; if (ext_gnt !== 1'b1) begin errs++; $display("FAIL starve_ext_alone: got %b want 1", ext_gnt); end
      idle();
   endtask

   task automatic test_collision();
      for (int i = 0; i < 4; i++) drive(0, 1, 10'h070, 32'h1, 1, 1, 10'h070, 32'h2);
      drive(0, 1, 10'h070, 32'h1, 1, 1, 10'h070, 32'h2);
      checks++; if (ext_gnt !== 1'b1 || mem_wen !== 1'b1 || mem_wdata !== 32'h2) begin errs++; $display("FAIL coll_forced: gnt %b wen %b data %h want 1 1 2", ext_gnt, mem_wen, mem_wdata); end
      drive(0, 1, 10'h070, 32'h1, 0, 0, '0, '0);
      checks++; if (sram[10'h070] !== 32'h2) begin errs++; $display("FAIL coll_mem_ext: got %h want 2", sram[10'h070]); end
      checks++; if (cpu_stall !== 1'b0 || mem_wdata !== 32'h1) begin errs++; $display("FAIL coll_retry: stall %b data %h want 0 1", cpu_stall, mem_wdata); end
      drive(1, 0, 10'h070, '0, 0, 0, '0, '0);
      idle();
      checks++; if (cpu_rdata !== 32'h1) begin errs++; $display("FAIL coll_final: got %h want 1", cpu_rdata); end
   endtask

   task automatic test_reset_mid();
      drive(0, 0, '0, '0, 1, 0, 10'h020, '0);
      checks++; if (ext_gnt !== 1'b1) begin errs++; $display("FAIL rmid_gnt: got %b want 1", ext_gnt); end
      arst_n = 1'b0; #1;
      checks++; if (ext_gnt !== 1'b0 || mem_ren !== 1'b0) begin errs++; $display("FAIL rmid_gnt_masked: gnt %b ren %b want 0 0", ext_gnt, mem_ren); end
      idle();
      arst_n = 1'b1;
      checks++; if (ext_rvalid !== 1'b0) begin errs++; $display("FAIL rmid_rvalid: got %b want 0", ext_rvalid); end
      for (int i = 0; i < 3; i++) drive(1, 0, 10'h030, '0, 1, 0, 10'h020, '0);
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 10'h030, '0, 1, 0, 10'h020, '0);
         if (k == 0) begin arst_n = 1'b0; #1; arst_n = 1'b1; #1; end
         checks++; if (ext_gnt !== (k == 4)) begin errs++; $display("FAIL rmid_wait_clear%0d: got %b want %b", k, ext_gnt, k == 4); end
      end
      idle();
   endtask

   task automatic test_random();
      logic [DW-1:0] mm [0:7];
      logic cr = 0, cw = 0, er = 0, ew = 0, stalled = 0, pend = 0, creq, ewin, cwin, exp_rv = 0;
      logic [AW-1:0] ca = '0, ea = '0, exp_addr;
      logic [DW-1:0] cd = '0, ed = '0, exp_erd = '0, exp_crd = '0, exp_wd;
      int lose = 0;
      for (int i = 0; i < 8; i++) mm[i] = '0;
      reset_pulse();
      for (int n = 0; n < 400; n++) begin
         if (!stalled) begin
            cr = 1'($urandom); cw = ($urandom % 3) == 0;
            ca = 10'(10'h100 + $urandom % 8); cd = $urandom;
         end
         if (!pend) begin
            er = ($urandom % 4) != 0; ew = 1'($urandom);
            ea = 10'(10'h100 + $urandom % 8); ed = $urandom;
         end
         drive(cr, cw, ca, cd, er, ew, ea, ed);
         checks++; if (ext_rvalid !== exp_rv || ext_rdata !== (exp_rv ? exp_erd : '0)) begin errs++; $display("FAIL rnd_ext_rd@%0d: rvalid %b data %h want %b %h", n, ext_rvalid, ext_rdata, exp_rv, exp_rv ? exp_erd : '0); end
         checks++; if (cpu_rdata !== exp_crd) begin errs++; $display("FAIL rnd_cpu_rd@%0d: got %h want %h", n, cpu_rdata, exp_crd); end
         creq = cr | cw;
         ewin = er && (!creq || lose == MW);
         cwin = creq && !ewin;
         exp_addr = ewin ? ea : cwin ? ca : '0;
         exp_wd = ewin ? ed : cwin ? cd : '0;
         checks++; if (ext_gnt !== ewin || cpu_stall !== (creq && !cwin)) begin errs++; $display("FAIL rnd_arb@%0d: gnt %b stall %b want %b %b", n, ext_gnt, cpu_stall, ewin, creq && !cwin); end
         checks++; if (mem_wen !== ((ewin && ew) || (cwin && cw)) || mem_ren !== ((ewin && !ew) || (cwin && !cw)) || mem_addr !== exp_addr || mem_wdata !== exp_wd) begin errs++; $display("FAIL rnd_mem@%0d: wen %b ren %b addr %h data %h want addr %h data %h", n, mem_wen, mem_ren, mem_addr, mem_wdata, exp_addr, exp_wd); end
         exp_rv = ewin && !ew;
         if (exp_rv) exp_erd = mm[ea[2:0]];
         if (cwin && !cw) exp_crd = mm[ca[2:0]];
         if (ewin && ew) mm[ea[2:0]] = ed;
         if (cwin && cw) mm[ca[2:0]] = cd;
         lose = (ewin || !er) ? 0 : lose + 1;
         stalled = creq && !cwin;
         pend = er && !ewin;
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cpu_rw();
      test_ext_read();
      test_starvation();
      test_collision();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
